// File: rtl/tech_ram_arb.sv
// Round-robin arbiter and sequencer sharing one single-port RAM macro between
// REQ_NUM valid/ready requesters, with optional post-reset zero-fill of the array.
module tech_ram_arb #(
    parameter int REQ_NUM    = 2,
    parameter int BIT_WIDTH  = 128,
    parameter int WORD_DEPTH = 64,
    parameter int INIT_EN    = 1,
    localparam int AW        = $clog2(WORD_DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [REQ_NUM-1:0]           req_valid_i,
    output logic [REQ_NUM-1:0]           req_ready_o,
    input  logic [REQ_NUM-1:0]           req_we_i,
    input  logic [REQ_NUM*AW-1:0]        req_addr_i,
    input  logic [REQ_NUM*BIT_WIDTH-1:0] req_dat_i,
    output logic [REQ_NUM-1:0]           rsp_valid_o,
    output logic [BIT_WIDTH-1:0]         rsp_dat_o,
    output logic                         init_done_o,
    output logic                         ram_en_o,
    output logic                         ram_wen_o,
    output logic [AW-1:0]                ram_addr_o,
    output logic [BIT_WIDTH-1:0]         ram_dat_o,
    input  logic [BIT_WIDTH-1:0]         ram_dat_i
);

    localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_DEPTH - 1);
    localparam logic [PW-1:0] LAST_REQ  = PW'(REQ_NUM - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RST_STATE     = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic   RST_INIT_DONE = (INIT_EN != 0) ? 1'b0 : 1'b1;

    state_e               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [REQ_NUM-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 init_done_q, init_done_d;

    logic                 gnt_vld_s;
    logic [PW-1:0]        gnt_idx_s;
    logic [REQ_NUM-1:0]   ready_s;
    logic                 ram_en_s;
    logic                 ram_wen_s;
    logic [AW-1:0]        ram_addr_s;
    logic [BIT_WIDTH-1:0] ram_dat_s;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (!gnt_vld_s && req_valid_i[(int'(ptr_q) + k) % REQ_NUM]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = PW'((int'(ptr_q) + k) % REQ_NUM);
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
        if (state_q != ST_RUN) begin
            gnt_vld_s = 1'b0;
        end else begin
            gnt_vld_s = gnt_vld_s;
        end
    end

    // Next state, macro drive and response tracking for INIT and RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        rsp_valid_d = '0;
        ready_s     = '0;
        ram_en_s    = 1'b1;
        ram_wen_s   = 1'b1;
        ram_addr_s  = '0;
        ram_dat_s   = '0;
        case (state_q)
            ST_INIT: begin
                ram_en_s   = 1'b0;
                ram_wen_s  = 1'b0;
                ram_addr_s = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (gnt_vld_s) begin
                    ready_s[gnt_idx_s]     = 1'b1;
                    ram_en_s               = 1'b0;
                    ram_wen_s              = ~req_we_i[gnt_idx_s];
                    ram_addr_s             = req_addr_i[int'(gnt_idx_s)*AW +: AW];
                    ram_dat_s              = req_dat_i[int'(gnt_idx_s)*BIT_WIDTH +: BIT_WIDTH];
                    rsp_valid_d[gnt_idx_s] = ~req_we_i[gnt_idx_s];
                    ptr_d = (gnt_idx_s == LAST_REQ) ? '0 : gnt_idx_s + PW'(1);
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // State, counter, pointer and response-owner registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            init_done_q <= RST_INIT_DONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            init_done_q <= init_done_d;
        end
    end

    assign req_ready_o = ready_s;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = ram_dat_i;
    assign init_done_o = init_done_q;
    assign ram_en_o    = ram_en_s;
    assign ram_wen_o   = ram_wen_s;
    assign ram_addr_o  = ram_addr_s;
    assign ram_dat_o   = ram_dat_s;

endmodule

// File: tb/tb_tech_ram_arb.sv
// Directed bench for tech_ram_arb: a behavioural RAM macro behind the arbiter,
// plus a second instance with INIT_EN=0 for the no-init reset behaviour.
module tb_tech_ram_arb;

    localparam int RN = 2;
    localparam int BW = 128;
    localparam int WD = 64;
    localparam int AW = 6;

    logic            clk;
    logic            rst_n;
    logic [RN-1:0]   req_valid, req_ready, req_we, rsp_valid;
    logic [RN*AW-1:0] req_addr;
    logic [RN*BW-1:0] req_dat;
    logic [BW-1:0]   rsp_dat, ram_wdat, ram_q;
    logic            init_done, ram_en, ram_wen;
    logic [AW-1:0]   ram_addr;

    logic            rst2_n;
    logic [RN-1:0]   req_valid2, req_ready2, req_we2, rsp_valid2;
    logic [RN*AW-1:0] req_addr2;
    logic [RN*BW-1:0] req_dat2;
    logic [BW-1:0]   rsp_dat2, ram_wdat2, ram_q2;
    logic            init_done2, ram_en2, ram_wen2;
    logic [AW-1:0]   ram_addr2;

    logic [BW-1:0]   mem [WD];

    int nvec;
    int nerr;

    tech_ram_arb #(.REQ_NUM(RN), .BIT_WIDTH(BW), .WORD_DEPTH(WD), .INIT_EN(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_dat_i(req_dat),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .init_done_o(init_done),
        .ram_en_o(ram_en), .ram_wen_o(ram_wen), .ram_addr_o(ram_addr),
        .ram_dat_o(ram_wdat), .ram_dat_i(ram_q));

    tech_ram_arb #(.REQ_NUM(RN), .BIT_WIDTH(BW), .WORD_DEPTH(WD), .INIT_EN(0)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst2_n), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
        .req_we_i(req_we2), .req_addr_i(req_addr2), .req_dat_i(req_dat2),
        .rsp_valid_o(rsp_valid2), .rsp_dat_o(rsp_dat2), .init_done_o(init_done2),
        .ram_en_o(ram_en2), .ram_wen_o(ram_wen2), .ram_addr_o(ram_addr2),
        .ram_dat_o(ram_wdat2), .ram_dat_i(ram_q2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port macro: active-low enable/write-enable, registered read.
    always @(posedge clk) begin
        if (!ram_en) begin
            if (!ram_wen) mem[ram_addr] <= ram_wdat;
            else          ram_q <= mem[ram_addr];
        end
    end

    assign ram_q2 = 128'hBEEF;

    task automatic test_reset();
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        nvec++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid); end
        nvec++; if (init_done !== 1'b0) begin nerr++; $display("FAIL rst_init_done: got %b exp 0", init_done); end
        nvec++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL rst_ready: got %b exp 00", req_ready); end
        nvec++; if (ram_en !== 1'b0 || ram_wen !== 1'b0) begin nerr++; $display("FAIL rst_ram_ctl: got en=%b wen=%b exp 0/0", ram_en, ram_wen); end
        nvec++; if (ram_addr !== 6'd0 || ram_wdat !== 128'd0) begin nerr++; $display("FAIL rst_ram_addr: got addr=%0d dat=%0h exp 0/0", ram_addr, ram_wdat); end
        req_valid = 2'b00;
    endtask

    task automatic test_init();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_we = 2'b00;
        for (int c = 0; c < WD; c++) begin
            #1;
            nvec++; if (ram_en !== 1'b0 || ram_wen !== 1'b0) begin nerr++; $display("FAIL init_ctl[%0d]: got en=%b wen=%b exp 0/0", c, ram_en, ram_wen); end
            nvec++; if (ram_addr !== 6'(c) || ram_wdat !== 128'd0) begin nerr++; $display("FAIL init_addr[%0d]: got addr=%0d dat=%0h exp %0d/0", c, ram_addr, ram_wdat, c); end
            nvec++; if (req_ready !== 2'b00 || init_done !== 1'b0) begin nerr++; $display("FAIL init_hold[%0d]: got ready=%b done=%b exp 00/0", c, req_ready, init_done); end
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        nvec++; if (init_done !== 1'b1) begin nerr++; $display("FAIL init_done: got %b exp 1", init_done); end
        nvec++; if (ram_en !== 1'b1 || ram_wen !== 1'b1 || ram_addr !== 6'd0) begin nerr++; $display("FAIL run_idle: got en=%b wen=%b addr=%0d exp 1/1/0", ram_en, ram_wen, ram_addr); end
    endtask

    task automatic test_first_read();
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr[5:0] = 6'd17;
        #1;
        nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL rd17_ready: got %b exp 01", req_ready); end
        nvec++; if (ram_en !== 1'b0 || ram_wen !== 1'b1 || ram_addr !== 6'd17) begin nerr++; $display("FAIL rd17_ram: got en=%b wen=%b addr=%0d exp 0/1/17", ram_en, ram_wen, ram_addr); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        nvec++; if (rsp_valid !== 2'b01 || rsp_dat !== 128'd0) begin nerr++; $display("FAIL rd17_rsp: got v=%b d=%0h exp 01/0", rsp_valid, rsp_dat); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr[5:0] = 6'd5; req_dat[127:0] = 128'hA5A5;
        #1;
        nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL wr5_ready: got %b exp 01", req_ready); end
        nvec++; if (ram_en !== 1'b0 || ram_wen !== 1'b0 || ram_addr !== 6'd5 || ram_wdat !== 128'hA5A5) begin nerr++; $display("FAIL wr5_ram: got en=%b wen=%b addr=%0d dat=%0h exp 0/0/5/a5a5", ram_en, ram_wen, ram_addr, ram_wdat); end
        @(negedge clk);
        req_we = 2'b00;
        #1;
        nvec++; if (req_ready !== 2'b01 || ram_wen !== 1'b1) begin nerr++; $display("FAIL rd5_issue: got ready=%b wen=%b exp 01/1", req_ready, ram_wen); end
        nvec++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL wr_no_rsp: got %b exp 00", rsp_valid); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        nvec++; if (rsp_valid !== 2'b01 || rsp_dat !== 128'hA5A5) begin nerr++; $display("FAIL rd5_rsp: got v=%b d=%0h exp 01/a5a5", rsp_valid, rsp_dat); end
        // Seed addr 1 and 2 for the arbitration tests; pointer ends back at 0.
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr[5:0] = 6'd1; req_dat[127:0] = 128'h1111;
        #1;
        nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL wr1_ready: got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b10; req_addr[11:6] = 6'd2; req_dat[255:128] = 128'h2222;
        #1;
        nvec++; if (req_ready !== 2'b10 || ram_addr !== 6'd2) begin nerr++; $display("FAIL wr2_ready: got ready=%b addr=%0d exp 10/2", req_ready, ram_addr); end
        @(negedge clk);
        req_valid = 2'b00; req_we = 2'b00;
    endtask

    task automatic test_round_robin();
        req_valid = 2'b11; req_we = 2'b00; req_addr[5:0] = 6'd1; req_addr[11:6] = 6'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            nvec++; if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin nerr++; $display("FAIL rr_ready[%0d]: got %b exp %b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10); end
            nvec++; if (ram_addr !== ((c % 2 == 0) ? 6'd1 : 6'd2)) begin nerr++; $display("FAIL rr_addr[%0d]: got %0d exp %0d", c, ram_addr, (c % 2 == 0) ? 1 : 2); end
            if (c > 0) begin
                nvec++; if (rsp_valid !== ((c % 2 == 0) ? 2'b10 : 2'b01) || rsp_dat !== ((c % 2 == 0) ? 128'h2222 : 128'h1111)) begin nerr++; $display("FAIL rr_rsp[%0d]: got v=%b d=%0h", c, rsp_valid, rsp_dat); end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        nvec++; if (rsp_valid !== 2'b10 || rsp_dat !== 128'h2222) begin nerr++; $display("FAIL rr_rsp_last: got v=%b d=%0h exp 10/2222", rsp_valid, rsp_dat); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]   tbl [8];
        logic [127:0] exp [8];
        tbl = '{6'd1, 6'd2, 6'd5, 6'd17, 6'd1, 6'd2, 6'd5, 6'd17};
        exp = '{128'h1111, 128'h2222, 128'hA5A5, 128'h0, 128'h1111, 128'h2222, 128'hA5A5, 128'h0};
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b00;
        for (int c = 0; c < 8; c++) begin
            req_addr[11:6] = tbl[c];
            #1;
            nvec++; if (req_ready !== 2'b10 || ram_addr !== tbl[c]) begin nerr++; $display("FAIL b2b_issue[%0d]: got ready=%b addr=%0d exp 10/%0d", c, req_ready, ram_addr, tbl[c]); end
            if (c > 0) begin
                nvec++; if (rsp_valid !== 2'b10 || rsp_dat !== exp[c-1]) begin nerr++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%0h exp 10/%0h", c, rsp_valid, rsp_dat, exp[c-1]); end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        nvec++; if (rsp_valid !== 2'b10 || rsp_dat !== exp[7]) begin nerr++; $display("FAIL b2b_rsp_last: got v=%b d=%0h exp 10/0", rsp_valid, rsp_dat); end
        req_valid = 2'b11;
        #1;
        nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL b2b_ptr: got %b exp 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr[5:0] = 6'd5;
        #1;
        nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL mid_ready: got %b exp 01", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        nvec++; if (rsp_valid !== 2'b01) begin nerr++; $display("FAIL mid_rsp_pre: got %b exp 01", rsp_valid); end
        rst_n = 1'b0;
        #1;
        nvec++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL mid_rsp_drop: got %b exp 00", rsp_valid); end
        nvec++; if (init_done !== 1'b0 || ram_en !== 1'b0 || ram_wen !== 1'b0 || ram_addr !== 6'd0) begin nerr++; $display("FAIL mid_rst_state: got done=%b en=%b wen=%b addr=%0d", init_done, ram_en, ram_wen, ram_addr); end
        repeat (2) @(negedge clk);
        #1;
        nvec++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL mid_rsp_held: got %b exp 00", rsp_valid); end
    endtask

    task automatic test_zero_readback();
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr[5:0] = 6'd5;
        #1;
        nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL zr_ready: got %b exp 01", req_ready); end
        @(negedge clk);
        req_addr[5:0] = 6'd1;
        #1;
        nvec++; if (rsp_valid !== 2'b01 || rsp_dat !== 128'd0) begin nerr++; $display("FAIL zr_rsp5: got v=%b d=%0h exp 01/0", rsp_valid, rsp_dat); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        nvec++; if (rsp_valid !== 2'b01 || rsp_dat !== 128'd0) begin nerr++; $display("FAIL zr_rsp1: got v=%b d=%0h exp 01/0", rsp_valid, rsp_dat); end
    endtask

    task automatic test_no_init();
        @(negedge clk);
        #1;
        nvec++; if (init_done2 !== 1'b1 || rsp_valid2 !== 2'b00) begin nerr++; $display("FAIL ni_rst: got done=%b v=%b exp 1/00", init_done2, rsp_valid2); end
        req_valid2 = 2'b01; req_we2 = 2'b00; req_addr2[5:0] = 6'd3;
        rst2_n = 1'b1;
        #1;
        nvec++; if (req_ready2 !== 2'b01) begin nerr++; $display("FAIL ni_ready: got %b exp 01", req_ready2); end
        nvec++; if (ram_en2 !== 1'b0 || ram_wen2 !== 1'b1 || ram_addr2 !== 6'd3) begin nerr++; $display("FAIL ni_ram: got en=%b wen=%b addr=%0d exp 0/1/3", ram_en2, ram_wen2, ram_addr2); end
        @(negedge clk);
        req_valid2 = 2'b00;
        #1;
        nvec++; if (rsp_valid2 !== 2'b01 || rsp_dat2 !== 128'hBEEF || init_done2 !== 1'b1) begin nerr++; $display("FAIL ni_rsp: got v=%b d=%0h done=%b exp 01/beef/1", rsp_valid2, rsp_dat2, init_done2); end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rst_n = 1'b0; rst2_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_dat = '0;
        req_valid2 = '0; req_we2 = '0; req_addr2 = '0; req_dat2 = '0;
        test_reset();
        test_init();
        test_first_read();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_init();
        test_zero_readback();
        test_no_init();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
